// File: rtl/timing_ctrl.sv
// Instruction/cycle sequencer: holds the current opcode and cycle count, and
// tracks pending reset, NMI and IRQ requests for the decoder.
module timing_ctrl #(
  parameter logic [7:0] INTOP = 8'h00
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] dbin,
  input  logic       icyc,
  input  logic       rcyc,
  input  logic       scyc,
  input  logic       sinst,
  input  logic       irqn,
  input  logic       nmin,
  input  logic       irqdis,
  output logic [7:0] inst,
  output logic [2:0] cycle,
  output logic       clrpend,
  output logic       nmipend,
  output logic       irqpend,
  output logic       sync,
  output logic       cycerr
);

  logic [7:0] inst_q, inst_d;
  logic [2:0] cycle_q, cycle_d;
  logic       clrpend_q, clrpend_d;
  logic       nmipend_q, nmipend_d;
  logic       irqpend_q, irqpend_d;
  logic       sync_q, sync_d;
  logic       cycerr_q, cycerr_d;
  logic       irq_s1_q, irq_s2_q;
  logic       nmi_s1_q, nmi_s2_q, nmi_prev_q;
  logic       nmi_fall;
  logic       any_pend;

  // Two-flop synchronizers, plus one extra stage on nmin for edge detection
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      irq_s1_q   <= 1'b1;
      irq_s2_q   <= 1'b1;
      nmi_s1_q   <= 1'b1;
      nmi_s2_q   <= 1'b1;
      nmi_prev_q <= 1'b1;
    end else begin
      irq_s1_q   <= irqn;
      irq_s2_q   <= irq_s1_q;
      nmi_s1_q   <= nmin;
      nmi_s2_q   <= nmi_s1_q;
      nmi_prev_q <= nmi_s2_q;
    end
  end

  assign nmi_fall = nmi_prev_q & ~nmi_s2_q;
  assign any_pend = clrpend_q | nmipend_q | irqpend_q;

  always_comb begin
    clrpend_d = clrpend_q;
    nmipend_d = nmipend_q;
    irqpend_d = ~irq_s2_q & ~irqdis;
    if (sinst) begin
      clrpend_d = 1'b0;
      if (!clrpend_q) nmipend_d = 1'b0;
    end
    // A new NMI edge outranks an acknowledge landing on the same edge
    if (nmi_fall) nmipend_d = 1'b1;
  end

  always_comb begin
    inst_d   = inst_q;
    cycle_d  = cycle_q;
    sync_d   = 1'b0;
    cycerr_d = cycerr_q;
    if (rcyc) begin
      cycle_d = 3'd0;
      sync_d  = 1'b1;
      inst_d  = any_pend ? INTOP : dbin;
    end else if (icyc) begin
      if (cycle_q == 3'd7) cycerr_d = 1'b1;
      cycle_d = cycle_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      inst_q    <= INTOP;
      cycle_q   <= 3'd0;
      clrpend_q <= 1'b1;
      nmipend_q <= 1'b0;
      irqpend_q <= 1'b0;
      sync_q    <= 1'b1;
      cycerr_q  <= 1'b0;
    end else begin
      inst_q    <= inst_d;
      cycle_q   <= cycle_d;
      clrpend_q <= clrpend_d;
      nmipend_q <= nmipend_d;
      irqpend_q <= irqpend_d;
      sync_q    <= sync_d;
      cycerr_q  <= cycerr_d;
    end
  end

  assign inst    = inst_q;
  assign cycle   = cycle_q;
  assign clrpend = clrpend_q;
  assign nmipend = nmipend_q;
  assign irqpend = irqpend_q;
  assign sync    = sync_q;
  assign cycerr  = cycerr_q;

endmodule

// File: tb/tb_timing_ctrl.sv
// Directed bench for timing_ctrl: reset, fetch/cycle sequencing, interrupt
// pending logic and asynchronous abort.
module tb_timing_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] dbin = 8'h00;
  logic       icyc = 1'b0, rcyc = 1'b0, scyc = 1'b0, sinst = 1'b0;
  logic       irqn = 1'b1, nmin = 1'b1, irqdis = 1'b0;
  logic [7:0] inst;
  logic [2:0] cycle;
  logic       clrpend, nmipend, irqpend, sync, cycerr;

  int n_checks = 0;
  int n_fail   = 0;

  timing_ctrl #(.INTOP(8'h00)) dut (
    .clk(clk), .clr(clr), .dbin(dbin),
    .icyc(icyc), .rcyc(rcyc), .scyc(scyc), .sinst(sinst),
    .irqn(irqn), .nmin(nmin), .irqdis(irqdis),
    .inst(inst), .cycle(cycle),
    .clrpend(clrpend), .nmipend(nmipend), .irqpend(irqpend),
    .sync(sync), .cycerr(cycerr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 clr = 1'b0;
    #1;
    check("rst_inst", inst, 8'h00);
    check("rst_cycle", {5'd0, cycle}, 8'd0);
    check("rst_clrpend", {7'd0, clrpend}, 8'd1);
    check("rst_nmipend", {7'd0, nmipend}, 8'd0);
    check("rst_irqpend", {7'd0, irqpend}, 8'd0);
    check("rst_sync", {7'd0, sync}, 8'd1);
    check("rst_cycerr", {7'd0, cycerr}, 8'd0);
    tick(2);
    clr = 1'b1;
    tick(1);
    check("rel_inst", inst, 8'h00);
    check("rel_cycle", {5'd0, cycle}, 8'd0);
    check("rel_clrpend", {7'd0, clrpend}, 8'd1);

    // Count 1..7 then acknowledge the reset request
    icyc = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check("count", {5'd0, cycle}, 8'(i));
    end
    icyc = 1'b0;
    sinst = 1'b1;
    tick(1);
    sinst = 1'b0;
    check("ack_clrpend", {7'd0, clrpend}, 8'd0);
    check("ack_nmipend", {7'd0, nmipend}, 8'd0);
    check("ack_sync", {7'd0, sync}, 8'd0);

    // Normal fetch
    dbin = 8'hA9; rcyc = 1'b1;
    tick(1);
    rcyc = 1'b0;
    check("fetch_inst", inst, 8'hA9);
    check("fetch_cycle", {5'd0, cycle}, 8'd0);
    check("fetch_sync", {7'd0, sync}, 8'd1);
    icyc = 1'b1;
    tick(1);
    icyc = 1'b0;
    check("inc_cycle", {5'd0, cycle}, 8'd1);
    check("inc_sync", {7'd0, sync}, 8'd0);
    scyc = 1'b1;
    tick(1);
    check("stall_cycle", {5'd0, cycle}, 8'd1);
    icyc = 1'b1;
    tick(1);
    icyc = 1'b0; scyc = 1'b0;
    check("icyc_over_scyc", {5'd0, cycle}, 8'd2);
    check("hold_inst", inst, 8'hA9);

    // Level IRQ through synchronizer, then masked
    irqn = 1'b0; irqdis = 1'b0;
    tick(2);
    check("irq_lat2", {7'd0, irqpend}, 8'd0);
    tick(1);
    check("irq_lat3", {7'd0, irqpend}, 8'd1);
    dbin = 8'hEA; rcyc = 1'b1;
    tick(1);
    rcyc = 1'b0;
    check("irq_intop", inst, 8'h00);
    check("irq_fetch_cycle", {5'd0, cycle}, 8'd0);
    irqdis = 1'b1;
    tick(1);
    check("irq_masked", {7'd0, irqpend}, 8'd0);
    irqn = 1'b1;
    tick(3);
    irqdis = 1'b0;
    tick(1);
    check("irq_released", {7'd0, irqpend}, 8'd0);

    // rcyc beats icyc, then cycle-counter overrun
    dbin = 8'h5A; rcyc = 1'b1;
    tick(1);
    rcyc = 1'b0;
    check("fetch2_inst", inst, 8'h5A);
    icyc = 1'b1;
    tick(5);
    check("at5", {5'd0, cycle}, 8'd5);
    rcyc = 1'b1;
    tick(1);
    rcyc = 1'b0;
    check("rcyc_wins_cycle", {5'd0, cycle}, 8'd0);
    check("rcyc_wins_sync", {7'd0, sync}, 8'd1);
    tick(7);
    check("at7", {5'd0, cycle}, 8'd7);
    check("no_err_yet", {7'd0, cycerr}, 8'd0);
    tick(1);
    check("wrap_cycle", {5'd0, cycle}, 8'd0);
    check("wrap_cycerr", {7'd0, cycerr}, 8'd1);
    check("wrap_inst", inst, 8'h5A);
    icyc = 1'b0;
    tick(1);
    check("cycerr_sticky", {7'd0, cycerr}, 8'd1);

    // NMI pulse: set once after edge detect
    nmin = 1'b0;
    tick(2);
    check("nmi_lat2", {7'd0, nmipend}, 8'd0);
    tick(1);
    check("nmi_set", {7'd0, nmipend}, 8'd1);
    tick(1);
    nmin = 1'b1;
    tick(3);
    check("nmi_hold", {7'd0, nmipend}, 8'd1);
    sinst = 1'b1;
    tick(1);
    sinst = 1'b0;
    check("nmi_ack", {7'd0, nmipend}, 8'd0);

    // Held-low NMI produces one request only
    nmin = 1'b0;
    tick(3);
    check("nmi_set2", {7'd0, nmipend}, 8'd1);
    sinst = 1'b1;
    tick(1);
    sinst = 1'b0;
    check("nmi_ack2", {7'd0, nmipend}, 8'd0);
    tick(5);
    check("nmi_no_reset", {7'd0, nmipend}, 8'd0);

    // Edge coincident with acknowledge: set wins
    nmin = 1'b1;
    tick(3);
    nmin = 1'b0;
    tick(3);
    check("nmi_set3", {7'd0, nmipend}, 8'd1);
    nmin = 1'b1;
    tick(3);
    nmin = 1'b0;
    tick(2);
    sinst = 1'b1;
    tick(1);
    sinst = 1'b0;
    check("nmi_set_wins", {7'd0, nmipend}, 8'd1);

    // Asynchronous abort mid-instruction
    icyc = 1'b1;
    tick(4);
    icyc = 1'b0;
    check("pre_abort_cycle", {5'd0, cycle}, 8'd4);
    #2 clr = 1'b0;
    #1;
    check("abort_cycle", {5'd0, cycle}, 8'd0);
    check("abort_inst", inst, 8'h00);
    check("abort_nmipend", {7'd0, nmipend}, 8'd0);
    check("abort_clrpend", {7'd0, clrpend}, 8'd1);
    check("abort_cycerr", {7'd0, cycerr}, 8'd0);
    check("abort_sync", {7'd0, sync}, 8'd1);
    tick(1);
    clr = 1'b1;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
